prio_arbiter_n: RTL and testbench
=================================

Name: prio_arbiter_n

Overview:
- N-requester shared-resource arbiter; parametrised successor of the two-channel A/B arbiter.
- Grants one requester at a time using per-channel programmable priority.
- Breaks equal-priority ties round-robin.
- Holds the grant while the owner keeps requesting. Sits between bus masters and a single shared resource.

Parameters:
- N, 4, number of requesters (2..16)
- PW, 2, priority field width per requester; larger value = higher priority
- HOLD_MAX, 8, max consecutive grant cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  N  request per channel; bit i = channel i
- prio  in  N*PW  priorities; channel i at prio[i*PW +: PW]; sampled every cycle
- gnt  out  N  one-hot grant, registered; all-zero when idle
- gnt_id  out  max(1,$clog2(N))  index of granted channel; 0 when idle
- busy  out  1  1 when any grant is active
- preempt  out  1  one-cycle pulse when a grant is forcibly removed (always 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - Round-robin pointer rr_last = N-1, so channel 0 wins the first tie.
  - Hold counter = 0.
- Two states:
  - IDLE: gnt=0.
  - OWNED: exactly one gnt bit set.
- All decisions are taken at the rising clk edge from the current req/prio. Request-to-grant latency is 1 cycle.
- IDLE:
  - No req → stay IDLE.
  - Otherwise → OWNED, granting the winner.
- OWNED, owner's req still 1 → keep the grant, whatever other requests or priorities do. A higher priority arriving later does not preempt.
- OWNED, owner's req 0:
  - If other reqs are pending, grant the winner among them directly, with no idle cycle.
  - Otherwise go to IDLE.
- Winner selection:
  - Highest prio value among asserted reqs.
  - Ties: first asserted channel scanning upward from rr_last+1, wrapping modulo N.
- rr_last updates to the new owner's index on every new grant; it is unchanged while holding.
- Priority changes on a non-owner take effect at the next arbitration. Priority changes on the owner have no effect.
- gnt_id and busy are registered with gnt and always consistent with it.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). After release, arbitration restarts as from power-up.
- N=1: any req is granted and held; tie logic is degenerate.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A hold counter counts owner cycles. It is cleared on every new grant and in IDLE.
  - If the counter reaches HOLD_MAX-1 while any other req is pending, at the next edge the owner is released and the winner among the others is granted. The owner is excluded from that arbitration.
  - preempt pulses 1 for that cycle.
  - If no other req is pending, the owner keeps the grant and the counter saturates.
- When not defined: no counter logic, preempt tied to 0, and grants are held indefinitely.

Test Plan:
- Reset: rst=0 with req=4'b1111 → gnt=0, gnt_id=0, busy=0. Release reset, prio all 0 → next edge gnt=4'b0001.
- Single request: req=4'b0100 from idle → one edge later gnt=4'b0100, gnt_id=2, busy=1. Drop req → next edge gnt=0, busy=0.
- Hold, then direct handoff:
  - Ch1 owns, then req=4'b1010 with prio3=3 → gnt stays 4'b0010 while req1=1.
  - Drop req1 → next edge gnt=4'b1000 with no idle cycle.
- Priority: all prio=0 except ch2=3; req=4'b1111 simultaneously from idle → gnt=4'b0100.
- Round-robin ties: all prio equal, all four requesting, each owner drops req for one cycle after its grant → grant order 0,1,2,3,0.
- ARB_TIMEOUT_EN, HOLD_MAX=4:
  - Ch0 holds, ch1 requesting → after 4 grant cycles gnt=4'b0010 with a 1-cycle preempt pulse.
  - Ch0 alone holds 20 cycles → no preempt.

Source files
------------

// File: rtl/prio_arbiter_n.sv
// prio_arbiter_n: N-requester arbiter for one shared resource.
// Highest programmable priority wins, equal priorities break ties
// round-robin, and the owner keeps the grant while it keeps requesting.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (0 = reset)
//   req      request per channel, bit i = channel i
//   prio     channel i priority at prio[i*PW +: PW], larger wins
//   gnt      registered one-hot grant, zero when idle
//   gnt_id   index of the granted channel, zero when idle
//   busy     1 while a grant is active
//   preempt  one-cycle pulse when a grant is forcibly removed
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined: an owner that has held for HOLD_MAX cycles is released
//   when another channel is waiting (preempt pulses).
//   Undefined: grants are held indefinitely and preempt is 0.

module prio_arbiter_n #(
    parameter int N        = 4,
    parameter int PW       = 2,
    parameter int HOLD_MAX = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*PW-1:0] prio,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            busy,
    output logic            preempt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nstate;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_ngnt;
    logic [IW-1:0]   r_gnt_id;
    logic [IW-1:0]   w_nid;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   w_nrr;
    logic            r_busy;
    logic            w_new;

    logic [PW-1:0]   w_prio [N];
    logic [N-1:0]    w_cand;
    logic            w_win_any;
    logic [IW-1:0]   w_win_id;
    logic [PW-1:0]   w_best;
    logic [IW-1:0]   w_j;
    logic            w_owner_req;
    logic            w_timeout;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_prio[i] = prio[i*PW +: PW];
        end
    end

    // While owned, the owner never competes: either it dropped its
    // request or it is being forcibly released.
    assign w_cand = (r_state == S_OWNED) ? (req & ~r_gnt) : req;
    assign w_owner_req = req[r_gnt_id];

    // Scan in round-robin order starting after the last owner; a strict
    // greater-than keeps the first channel seen among equal priorities.
    always_comb begin
        int t;
        w_win_any = 1'b0;
        w_win_id  = '0;
        w_best    = '0;
        w_j       = '0;
        t         = 0;
        for (int k = 0; k < N; k++) begin
            t = int'(r_rr) + 1 + k;
            if (t >= N) begin
                t = t - N;
            end
            w_j = IW'(t);
            if (w_cand[w_j] && (!w_win_any || w_prio[w_j] > w_best)) begin
                w_win_any = 1'b1;
                w_win_id  = w_j;
                w_best    = w_prio[w_j];
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ngnt   = r_gnt;
        w_nid    = r_gnt_id;
        w_nrr    = r_rr;
        w_new    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_win_any) begin
                    w_nstate = S_OWNED;
                    w_ngnt   = N'(1) << w_win_id;
                    w_nid    = w_win_id;
                    w_nrr    = w_win_id;
                    w_new    = 1'b1;
                end
            end
            S_OWNED: begin
                if (w_owner_req && !w_timeout) begin
                    w_nstate = S_OWNED;
                end else if (w_win_any) begin
                    w_ngnt = N'(1) << w_win_id;
                    w_nid  = w_win_id;
                    w_nrr  = w_win_id;
                    w_new  = 1'b1;
                end else begin
                    w_nstate = S_IDLE;
                    w_ngnt   = '0;
                    w_nid    = '0;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_ngnt   = '0;
                w_nid    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_rr     <= IW'(N - 1);
        end else begin
            r_state  <= w_nstate;
            r_gnt    <= w_ngnt;
            r_gnt_id <= w_nid;
            r_busy   <= (w_nstate == S_OWNED);
            r_rr     <= w_nrr;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_preempt;
    logic          w_cnt_top;

    assign w_cnt_top = (r_cnt == CW'(HOLD_MAX - 1));
    assign w_timeout = w_cnt_top && (|(req & ~r_gnt));

    // Counter saturates at HOLD_MAX-1 when nobody else is waiting.
    // A new grant while the owner still requests is a forced release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_new && w_owner_req && (r_state == S_OWNED);
            if (w_nstate != S_OWNED || w_new) begin
                r_cnt <= '0;
            end else if (!w_cnt_top) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign preempt = r_preempt;
`else
    // No timeout: HOLD_MAX is always at least 1, so this never fires.
    assign w_timeout = (HOLD_MAX < 1);
    assign preempt   = 1'b0;
`endif

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// tb_prio_arbiter_n: directed scoreboard bench for prio_arbiter_n.
// Stimulus pushes hand-computed expectations; a monitor pops and checks.

module tb_prio_arbiter_n;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*PW-1:0] prio;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            busy;
    logic            preempt;

    typedef struct {
        logic [N-1:0] gnt;
        logic         pre;
        string        nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    prio_arbiter_n #(
        .N        (N),
        .PW       (PW),
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .prio    (prio),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] id_of(input logic [N-1:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Apply inputs at the falling edge; expectation is for the next rise.
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N*PW-1:0] p, input logic [N-1:0] eg,
                        input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        prio = p;
        e.gnt = eg;
        e.pre = ep;
        e.nm  = nm;
        q.push_back(e);
    endtask

    always begin
        exp_t e;
        logic [IW-1:0] eid;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            eid = id_of(e.gnt);
            checks++;
            if (gnt !== e.gnt || gnt_id !== eid || busy !== (|e.gnt)
                || preempt !== e.pre) begin
                errors++;
                $display("FAIL %s: got gnt=%b id=%0d busy=%b pre=%b, want gnt=%b id=%0d busy=%b pre=%b",
                         e.nm, gnt, gnt_id, busy, preempt,
                         e.gnt, eid, |e.gnt, e.pre);
            end
        end
    end

    initial begin
        rst  = 1'b0;
        req  = 4'b1111;
        prio = '0;

        step(0, 4'b1111, 8'h00, 4'b0000, 0, "reset0");
        step(0, 4'b1111, 8'h00, 4'b0000, 0, "reset1");
        step(1, 4'b1111, 8'h00, 4'b0001, 0, "first_tie");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "to_idle");

        step(1, 4'b0100, 8'h00, 4'b0100, 0, "single");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "single_drop");

        step(1, 4'b0010, 8'h00, 4'b0010, 0, "ch1_grant");
        step(1, 4'b1010, 8'hC0, 4'b0010, 0, "hold_hi_prio");
        step(1, 4'b1010, 8'hC0, 4'b0010, 0, "hold_hi_prio2");
        step(1, 4'b1000, 8'hC0, 4'b1000, 0, "handoff");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "handoff_idle");

        step(1, 4'b1111, 8'h30, 4'b0100, 0, "prio_ch2");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "prio_idle");

        step(1, 4'b1000, 8'h00, 4'b1000, 0, "rr_setup");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "rr_setup_idle");
        step(1, 4'b1111, 8'h00, 4'b0001, 0, "rr0");
        step(1, 4'b1110, 8'h00, 4'b0010, 0, "rr1");
        step(1, 4'b1101, 8'h00, 4'b0100, 0, "rr2");
        step(1, 4'b1011, 8'h00, 4'b1000, 0, "rr3");
        step(1, 4'b0111, 8'h00, 4'b0001, 0, "rr0_again");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "rr_idle");

`ifdef ARB_TIMEOUT_EN
        step(1, 4'b0001, 8'h00, 4'b0001, 0, "to_c1");
        step(1, 4'b0011, 8'h00, 4'b0001, 0, "to_c2");
        step(1, 4'b0011, 8'h00, 4'b0001, 0, "to_c3");
        step(1, 4'b0011, 8'h00, 4'b0001, 0, "to_c4");
        step(1, 4'b0011, 8'h00, 4'b0010, 1, "to_preempt");
        step(1, 4'b0011, 8'h00, 4'b0010, 0, "to_pulse_end");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "to_idle");
        for (int i = 0; i < 20; i++) begin
            step(1, 4'b0001, 8'h00, 4'b0001, 0, "alone_hold");
        end
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "alone_idle");
`else
        step(1, 4'b0001, 8'h00, 4'b0001, 0, "hold_c1");
        for (int i = 0; i < 12; i++) begin
            step(1, 4'b0011, 8'h00, 4'b0001, 0, "hold_forever");
        end
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "hold_idle");
`endif

        step(1, 4'b0100, 8'h00, 4'b0100, 0, "pre_async");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0
            || preempt !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b id=%0d busy=%b pre=%b, want all zero",
                     gnt, gnt_id, busy, preempt);
        end
        step(0, 4'b1111, 8'h00, 4'b0000, 0, "in_reset");
        step(1, 4'b1111, 8'h00, 4'b0001, 0, "restart_tie");
        step(1, 4'b0000, 8'h00, 4'b0000, 0, "end_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
